// File: rtl/axi_mem_slave_ram.sv
// AXI4 memory slave backed by an inferred byte-writable block RAM.
// Write and read paths are independent, each with one burst in flight.
// Both paths support FIXED, INCR and WRAP bursts, and return OKAY/SLVERR responses.
// Ports:
//   aclk, areset              clock, synchronous active-high reset
//   aw*/w*/b*                 AXI4 write address, write data, write response channels
//   ar*/r*                    AXI4 read address, read data channels
module axi_mem_slave_ram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [7:0]            awlen,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;
    localparam int unsigned IDX_W1 = IDX_W + 1;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_X = IDX_W1'(DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    // Reserved burst type, or WRAP with an unsupported length: run as INCR, report SLVERR.
    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_err = (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    // Word index of the following beat; a legal WRAP length is a power-of-two-minus-one mask.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0] burst,
                                                  input logic [7:0] len);
        logic [IDX_W-1:0] inc;
        logic [IDX_W-1:0] mask;
        inc  = idx + IDX_W'(1);
        mask = IDX_W'(len);
        if (burst == BURST_FIXED) begin
            next_idx = idx;
        end else if ((burst == BURST_WRAP) && !burst_err(burst, len)) begin
            next_idx = (idx & ~mask) | (inc & mask);
        end else begin
            next_idx = inc;
        end
    endfunction

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        in_range = ({1'b0, idx} < DEPTH_X);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // Write path state
    w_state_e          w_state_q, w_state_d;
    logic [IDX_W-1:0]  w_idx_q,   w_idx_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic [7:0]        w_len_q,   w_len_d;
    logic [7:0]        w_cnt_q,   w_cnt_d;
    logic              w_err_q,   w_err_d;
    logic              awready_q, awready_d;
    logic              wready_q,  wready_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic [ID_W-1:0]   bid_q,     bid_d;
    logic              mem_we_c;

    // Read path state
    r_state_e          r_state_q, r_state_d;
    logic [IDX_W-1:0]  r_idx_q,   r_idx_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic [7:0]        r_len_q,   r_len_d;
    logic [7:0]        r_cnt_q,   r_cnt_d;
    logic              r_err_q,   r_err_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic              rlast_q,   rlast_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic [ID_W-1:0]   rid_q,     rid_d;
    logic [DATA_W-1:0] rdata_q;
    logic              fetch_c;

    // Byte-offset address bits and wlast carry no information for this slave.
    logic unused_c;
    assign unused_c = ^{wlast, awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

    // Write FSM: address, counted data beats, then a single response.
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_burst_d = w_burst_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        mem_we_c  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    w_idx_d   = awaddr[ADDR_W-1:OFF_W];
                    w_burst_d = awburst;
                    w_len_d   = awlen;
                    w_cnt_d   = 8'd0;
                    w_err_d   = burst_err(awburst, awlen);
                    bid_d     = awid;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    mem_we_c = in_range(w_idx_q) && !areset;
                    w_err_d  = w_err_q || !in_range(w_idx_q);
                    w_idx_d  = next_idx(w_idx_q, w_burst_q, w_len_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_cnt_q == w_len_q) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: r_idx_q always points at the next beat to fetch; each fetch refills the output register.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_burst_d = r_burst_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        fetch_c   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    r_idx_d   = araddr[ADDR_W-1:OFF_W];
                    r_burst_d = arburst;
                    r_len_d   = arlen;
                    r_cnt_d   = 8'd0;
                    r_err_d   = burst_err(arburst, arlen);
                    rid_d     = arid;
                    arready_d = 1'b0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: fetch_c = 1'b1;
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        fetch_c = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (fetch_c) begin
            rvalid_d  = 1'b1;
            rlast_d   = (r_cnt_q == r_len_q);
            rresp_d   = (r_err_q || !in_range(r_idx_q)) ? RESP_SLVERR : RESP_OKAY;
            r_idx_d   = next_idx(r_idx_q, r_burst_q, r_len_q);
            r_cnt_d   = r_cnt_q + 8'd1;
            r_state_d = R_DATA;
        end
    end

    // Control and response registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_burst_q <= 2'd0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'd0;
            bid_q     <= '0;
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_burst_q <= 2'd0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_err_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'd0;
            rid_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_burst_q <= w_burst_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_burst_q <= r_burst_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
        end
    end

    // RAM write port: per-byte enables, contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we_c) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[w_idx_q[MEM_AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // RAM read port: read-before-write on a same-word collision; out-of-range beats read as zero.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rdata_q <= '0;
        end else if (fetch_c) begin
            rdata_q <= in_range(r_idx_q) ? mem[r_idx_q[MEM_AW-1:0]] : '0;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;

endmodule

// File: doc/axi_mem_slave_ram.md
# axi_mem_slave_ram

Synthesizable, parametrised AXI4 memory slave: the RTL successor to the slave-VIP memory model used as the DUT endpoint in our AXI test chip. It accepts AXI4 write and read bursts (FIXED/INCR/WRAP) with byte strobes into an inferred block RAM. It returns OKAY/SLVERR responses, so it can sit behind the AXI master or passthrough in `chip` and in accelerator-card tests without a VIP licence.

## Interface
- DATA_W, 64, data bus width in bits (power of 2, 32..512)
- ADDR_W, 16, byte address width
- ID_W, 4, AXI ID width
- DEPTH, 1024, memory depth in DATA_W words (≤ 2^(ADDR_W−log2(DATA_W/8)))

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- awid / arid  in  ID_W  write / read address ID
- awaddr / araddr  in  ADDR_W  burst start byte address
- awlen / arlen  in  8  beats − 1
- awburst / arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- awvalid / arvalid  in  1  address valid
- awready / arready  out  1  address ready
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables
- wlast  in  1  last write beat (informational only)
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bid / rid  out  ID_W  response ID (echo of awid / arid)
- bresp / rresp  out  2  response, 2'b00 OKAY, 2'b10 SLVERR
- bvalid / rvalid  out  1  response / read data valid
- bready / rready  in  1  response / read data ready
- rdata  out  DATA_W  read data
- rlast  out  1  last read beat

## Operation
- Write and read paths are independent FSMs; one outstanding burst per path; no reordering.
- Write FSM: W_IDLE (awready=1) → AW handshake → W_DATA (wready=1). Beats counted against awlen; wlast ignored. Last counted beat → W_RESP (bvalid=1) → B handshake → W_IDLE.
- Read FSM: R_IDLE (arready=1) → AR handshake → R_DATA. Beats counted against arlen; rlast=1 on beat arlen. Final R handshake → R_IDLE.
- Word index = addr[ADDR_W−1 : log2(DATA_W/8)]; low byte-offset bits ignored (all beats full width).
- Next address: FIXED unchanged; INCR +1 word (wraps mod 2^index width); WRAP increments inside an aligned block of (len+1) words.
- WRAP with len ∉ {1,3,7,15}, and burst=3: executed as INCR, flagged error.
- Writes: each accepted beat updates bytes where wstrb=1 at that edge; strobe 0 bytes unchanged.
- Out-of-range index (≥ DEPTH): write beat dropped; read beat returns rdata=0 with rresp=SLVERR.
- bresp = SLVERR if any beat of the burst was out of range or burst flagged error, else OKAY.
- rresp per beat = SLVERR if that beat out of range or burst flagged error, else OKAY.
- Same-word read and write in one cycle: read returns pre-write data.

## Timing
- Reset (areset=1 sampled at edge): awready=arready=wready=0, bvalid=rvalid=rlast=0, bresp=rresp=0, bid=rid=0, rdata=0; FSMs to idle; in-flight bursts abandoned without response. Memory contents not cleared.
- First cycle after reset release: awready=1, arready=1.
- AW handshake at edge T → wready=1 from T+1. Last beat at edge L → wready=0, bvalid=1 from L+1. B handshake at edge B → awready=1 from B+1.
- AR handshake at edge T → first rvalid=1 from T+2 (one RAM read cycle). With rready held high, beats continue back-to-back, 1 beat/cycle.
- rvalid=0: rdata/rresp/rlast don't-care. rvalid=1 and rready=0: rdata, rresp, rlast, rid held stable.
- bid/rid latched at address handshake; stable while valid.

## Test plan
- Reset: hold areset 3 cycles → all outputs 0. First cycle after release → awready=arready=1.
- INCR write awaddr=0x0100, awlen=3, data 0x11..0x44, wstrb=all-ones → bresp=OKAY, bid echoed. INCR read araddr=0x0100, arlen=3 → 0x11,0x22,0x33,0x44, rlast on 4th beat, first rvalid exactly 2 cycles after AR.
- WRAP read araddr=0x0110, arlen=3, DATA_W=64 → word order 2,3,0,1. WRAP arlen=2 → INCR order 2,3,4, rresp=SLVERR.
- Strobes: write 0xFFFF_FFFF_FFFF_FFFF, then wstrb=0x0F with 0 → read 0xFFFF_FFFF_0000_0000.
- Out of range, DEPTH=1024: write word 1023 INCR len=1 → bresp=SLVERR, word 1023 written. Read same → beat0 OKAY data, beat1 rdata=0 SLVERR.
- Backpressure/collision: rready toggled 1-0-0-1 → rdata stable while stalled. Concurrent write/read of same word in one cycle → old data returned. areset mid-burst → idle, no bvalid/rvalid.
